// File: rtl/gated_astable_square_oscillator.sv
// Gated astable square-wave oscillator with programmable high/low phase
// lengths, gate-to-idle control and a slew-limited signed 16-bit output.
//
// Ports:
//   clk, I_RST        system clock, asynchronous active-high reset
//   audio_clk_en      sample strobe; out only moves on this strobe
//   gate              1 = oscillate, 0 = return to idle (low)
//   high_cycles       requested high-phase length in clk cycles
//   low_cycles        requested low-phase length in clk cycles
//   load              capture high_cycles/low_cycles into pending registers
//   fm_offset         signed phase-length offset (SQWAVE_FM_EN builds only)
//   raw_out           unfiltered square level
//   cycle_done        one-cycle pulse on the last clock of each low phase
//   out               slew-limited audio sample
//
// Optional build macro: SQWAVE_FM_EN adds fm_offset, which is added to
// each phase length at reload and saturated to [1, 2^COUNTER_WIDTH-1].

module gated_astable_square_oscillator #(
    parameter int unsigned        COUNTER_WIDTH       = 32,
    parameter int unsigned        DEFAULT_HIGH_CYCLES = 520833,
    parameter int unsigned        DEFAULT_LOW_CYCLES  = 520833,
    parameter logic signed [15:0] HIGH_LEVEL          = 16'sd16384,
    parameter logic signed [15:0] LOW_LEVEL           = 16'sd0,
    parameter int unsigned        SLEW_STEP           = 2048
) (
    input  logic                            clk,
    input  logic                            I_RST,
    input  logic                            audio_clk_en,
    input  logic                            gate,
    input  logic [COUNTER_WIDTH-1:0]        high_cycles,
    input  logic [COUNTER_WIDTH-1:0]        low_cycles,
    input  logic                            load,
`ifdef SQWAVE_FM_EN
    input  logic signed [COUNTER_WIDTH-1:0] fm_offset,
`endif
    output logic                            raw_out,
    output logic                            cycle_done,
    output logic signed [15:0]              out
);

    localparam int W = COUNTER_WIDTH;
    localparam logic [W-1:0] DEF_HI = W'(DEFAULT_HIGH_CYCLES);
    localparam logic [W-1:0] DEF_LO = W'(DEFAULT_LOW_CYCLES);
    localparam logic signed [16:0] STEP = 17'(SLEW_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t r_state, w_state_nxt;
    logic [W-1:0] r_cnt, w_cnt_nxt;
    logic [W-1:0] r_pend_hi, r_pend_lo;
    logic [W-1:0] r_act_hi, r_act_lo;
    logic [W-1:0] w_act_hi_nxt, w_act_lo_nxt;
    logic         w_done;
    logic signed [15:0] r_out, w_out_nxt, w_target;
    logic signed [16:0] w_diff, w_abs, w_step;

    // Counter load value for a phase: effective length minus one, where a
    // programmed length of 0 behaves as 1.
`ifdef SQWAVE_FM_EN
    function automatic logic [W-1:0] f_reload(input logic [W-1:0] len);
        logic [W-1:0]       base;
        logic signed [W+1:0] sum;
        base = (len == '0) ? W'(1) : len;
        sum  = $signed({2'b00, base})
             + $signed({{2{fm_offset[W-1]}}, fm_offset});
        if (sum < $signed((W+2)'(1)))
            return '0;
        else if (sum > $signed({2'b00, {W{1'b1}}}))
            return {W{1'b1}} - W'(1);
        else
            return sum[W-1:0] - W'(1);
    endfunction
`else
    function automatic logic [W-1:0] f_reload(input logic [W-1:0] len);
        return (len == '0) ? '0 : len - W'(1);
    endfunction
`endif

    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pend_hi <= DEF_HI;
            r_pend_lo <= DEF_LO;
            r_act_hi  <= DEF_HI;
            r_act_lo  <= DEF_LO;
            r_out     <= LOW_LEVEL;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_act_hi <= w_act_hi_nxt;
            r_act_lo <= w_act_lo_nxt;
            if (load) begin
                r_pend_hi <= high_cycles;
                r_pend_lo <= low_cycles;
            end
            if (audio_clk_en)
                r_out <= w_out_nxt;
        end
    end

    // Both active lengths are refreshed from pending only at the start of a
    // full cycle, so a load never alters a cycle already in progress.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt - W'(1);
        w_act_hi_nxt = r_act_hi;
        w_act_lo_nxt = r_act_lo;
        w_done       = 1'b0;
        if (!gate) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt  = S_HIGH;
                    w_act_hi_nxt = r_pend_hi;
                    w_act_lo_nxt = r_pend_lo;
                    w_cnt_nxt    = f_reload(r_pend_hi);
                end
                S_HIGH: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_LOW;
                        w_cnt_nxt   = f_reload(r_act_lo);
                    end
                end
                S_LOW: begin
                    if (r_cnt == '0) begin
                        w_state_nxt  = S_HIGH;
                        w_act_hi_nxt = r_pend_hi;
                        w_act_lo_nxt = r_pend_lo;
                        w_cnt_nxt    = f_reload(r_pend_hi);
                        w_done       = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Slew limiter: diff is formed in 17 bits so the full signed 16-bit
    // span cannot overflow; a single step never passes the target because
    // stepping only happens when |diff| exceeds the step.
    always_comb begin
        w_target  = (r_state == S_HIGH) ? HIGH_LEVEL : LOW_LEVEL;
        w_diff    = $signed({w_target[15], w_target})
                  - $signed({r_out[15], r_out});
        w_abs     = w_diff[16] ? -w_diff : w_diff;
        w_step    = w_diff[16] ? $signed({r_out[15], r_out}) - STEP
                               : $signed({r_out[15], r_out}) + STEP;
        w_out_nxt = w_target;
        if (SLEW_STEP != 0 && w_abs > STEP)
            w_out_nxt = w_step[15:0];
    end

    assign raw_out    = (r_state == S_HIGH);
    assign cycle_done = w_done;
    assign out        = r_out;

endmodule

// File: tb/tb_gated_astable_square_oscillator.sv
// Directed bench for gated_astable_square_oscillator: one instance without
// slew limiting for timing checks, one with slew limiting for ramp checks.
module tb_gated_astable_square_oscillator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b0, gate_a = 1'b0, load_a = 1'b0;
    logic en_b = 1'b0, gate_b = 1'b0, load_b = 1'b0;
    logic [31:0] hi = 32'd0, lo = 32'd0;
`ifdef SQWAVE_FM_EN
    logic signed [31:0] fm = 32'sd0;
`endif
    logic raw_a, done_a, raw_b, done_b;
    logic signed [15:0] out_a, out_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gated_astable_square_oscillator #(
        .DEFAULT_HIGH_CYCLES(10),
        .DEFAULT_LOW_CYCLES(10),
        .SLEW_STEP(0)
    ) dut_a (
        .clk(clk), .I_RST(rst), .audio_clk_en(en_a), .gate(gate_a),
        .high_cycles(hi), .low_cycles(lo), .load(load_a),
`ifdef SQWAVE_FM_EN
        .fm_offset(fm),
`endif
        .raw_out(raw_a), .cycle_done(done_a), .out(out_a)
    );

    gated_astable_square_oscillator #(
        .DEFAULT_HIGH_CYCLES(40),
        .DEFAULT_LOW_CYCLES(40),
        .SLEW_STEP(2048)
    ) dut_b (
        .clk(clk), .I_RST(rst), .audio_clk_en(en_b), .gate(gate_b),
        .high_cycles(hi), .low_cycles(lo), .load(load_b),
`ifdef SQWAVE_FM_EN
        .fm_offset(fm),
`endif
        .raw_out(raw_b), .cycle_done(done_b), .out(out_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [31:0] h, input logic [31:0] l);
        gate_a = 1'b0;
        load_a = 1'b1;
        hi = h;
        lo = l;
        step();
        load_a = 1'b0;
        step();
    endtask

    task automatic test_reset();
        step();
        step();
        checks += 6;
        if (raw_a !== 1'b0) begin errors++; $display("FAIL reset raw_a got %b want 0", raw_a); end
        if (done_a !== 1'b0) begin errors++; $display("FAIL reset done_a got %b want 0", done_a); end
        if (out_a !== 16'sd0) begin errors++; $display("FAIL reset out_a got %0d want 0", out_a); end
        if (raw_b !== 1'b0) begin errors++; $display("FAIL reset raw_b got %b want 0", raw_b); end
        if (done_b !== 1'b0) begin errors++; $display("FAIL reset done_b got %b want 0", done_b); end
        if (out_b !== 16'sd0) begin errors++; $display("FAIL reset out_b got %0d want 0", out_b); end
        rst = 1'b0;
        en_a = 1'b1;
        step();
        checks++;
        if (raw_a !== 1'b0) begin errors++; $display("FAIL idle raw_a got %b want 0", raw_a); end
    endtask

    task automatic test_slew();
        int n;
        logic signed [15:0] e;
        gate_b = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            step();
            if (k <= 40) begin
                n = (k / 2) * 2048;
                e = 16'(n > 16384 ? 16384 : n);
            end else begin
                n = ((k - 40) / 2) * 2048;
                e = 16'(16384 - (n > 16384 ? 16384 : n));
            end
            checks += 2;
            if (out_b !== e) begin errors++; $display("FAIL slew out k=%0d got %0d want %0d", k, out_b, e); end
            if (raw_b !== (k <= 40)) begin errors++; $display("FAIL slew raw k=%0d got %b want %b", k, raw_b, k <= 40); end
            en_b = (k % 2 == 1);
        end
        gate_b = 1'b0;
        en_b = 1'b0;
    endtask

    task automatic test_basic();
        logic er, eo_hi, ed;
        gate_a = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            er = ((k - 1) % 20) < 10;
            eo_hi = (k >= 2) && (((k - 2) % 20) < 10);
            ed = (k % 20 == 0);
            checks += 3;
            if (raw_a !== er) begin errors++; $display("FAIL basic raw k=%0d got %b want %b", k, raw_a, er); end
            if (done_a !== ed) begin errors++; $display("FAIL basic done k=%0d got %b want %b", k, done_a, ed); end
            if (out_a !== (eo_hi ? 16'sd16384 : 16'sd0)) begin
                errors++;
                $display("FAIL basic out k=%0d got %0d want %0d", k, out_a, eo_hi ? 16384 : 0);
            end
        end
    endtask

    task automatic test_load_mid();
        logic er, ed;
        restart(10, 10);
        gate_a = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            step();
            er = (k <= 10) || (k >= 21 && k <= 23) || (k >= 31);
            ed = (k == 20) || (k == 30);
            checks += 2;
            if (raw_a !== er) begin errors++; $display("FAIL load_mid raw k=%0d got %b want %b", k, raw_a, er); end
            if (done_a !== ed) begin errors++; $display("FAIL load_mid done k=%0d got %b want %b", k, done_a, ed); end
            load_a = (k == 4);
            if (k == 4) begin hi = 3; lo = 7; end
        end
        load_a = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic er, ed;
        restart(3, 7);
        gate_a = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            er = (k <= 3) || (k >= 11 && k <= 13) || (k >= 21 && k <= 25);
            ed = (k == 10) || (k == 20) || (k == 30);
            checks += 2;
            if (raw_a !== er) begin errors++; $display("FAIL b2b raw k=%0d got %b want %b", k, raw_a, er); end
            if (done_a !== ed) begin errors++; $display("FAIL b2b done k=%0d got %b want %b", k, done_a, ed); end
            load_a = (k == 10);
            if (k == 10) begin hi = 5; lo = 5; end
        end
        load_a = 1'b0;
    endtask

    task automatic test_gate_drop();
        logic er;
        restart(10, 10);
        gate_a = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            step();
            er = (k <= 4) || (k >= 9 && k <= 18);
            checks += 2;
            if (raw_a !== er) begin errors++; $display("FAIL gate raw k=%0d got %b want %b", k, raw_a, er); end
            if (done_a !== 1'b0) begin errors++; $display("FAIL gate done k=%0d got %b want 0", k, done_a); end
            if (k == 4) gate_a = 1'b0;
            if (k == 8) gate_a = 1'b1;
        end
    endtask

    task automatic test_zero_len();
        restart(0, 0);
        gate_a = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks += 2;
            if (raw_a !== (k % 2 == 1)) begin errors++; $display("FAIL zero raw k=%0d got %b want %b", k, raw_a, k % 2 == 1); end
            if (done_a !== (k % 2 == 0)) begin errors++; $display("FAIL zero done k=%0d got %b want %b", k, done_a, k % 2 == 0); end
        end
    endtask

`ifdef SQWAVE_FM_EN
    task automatic test_fm();
        logic er;
        fm = -32'sd20;
        restart(10, 10);
        gate_a = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks += 2;
            if (raw_a !== (k % 2 == 1)) begin errors++; $display("FAIL fm_sat raw k=%0d got %b want %b", k, raw_a, k % 2 == 1); end
            if (done_a !== (k % 2 == 0)) begin errors++; $display("FAIL fm_sat done k=%0d got %b want %b", k, done_a, k % 2 == 0); end
        end
        fm = 32'sd5;
        restart(10, 10);
        gate_a = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            step();
            er = (k <= 15) || (k == 31);
            checks += 2;
            if (raw_a !== er) begin errors++; $display("FAIL fm_plus raw k=%0d got %b want %b", k, raw_a, er); end
            if (done_a !== (k == 30)) begin errors++; $display("FAIL fm_plus done k=%0d got %b want %b", k, done_a, k == 30); end
        end
        fm = 32'sd0;
    endtask
`endif

    task automatic test_reset_mid();
        restart(3, 7);
        gate_a = 1'b1;
        step();
        step();
        step();
        checks++;
        if (out_a !== 16'sd16384) begin errors++; $display("FAIL pre_reset out got %0d want 16384", out_a); end
        #2;
        rst = 1'b1;
        #1;
        checks += 3;
        if (raw_a !== 1'b0) begin errors++; $display("FAIL reset_mid raw got %b want 0", raw_a); end
        if (out_a !== 16'sd0) begin errors++; $display("FAIL reset_mid out got %0d want 0", out_a); end
        if (done_a !== 1'b0) begin errors++; $display("FAIL reset_mid done got %b want 0", done_a); end
        step();
        rst = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step();
            checks++;
            if (raw_a !== (k <= 10)) begin errors++; $display("FAIL reset_mid restart raw k=%0d got %b want %b", k, raw_a, k <= 10); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_slew();
        test_basic();
        test_load_mid();
        test_back_to_back();
        test_gate_drop();
        test_zero_len();
`ifdef SQWAVE_FM_EN
        test_fm();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
